// File: rtl/alu_ctrl_pkg.sv
// Shared constants and types for the ALU control decoder and the mult/div sequencer.
package alu_ctrl_pkg;

   // ALU operation codes
   localparam logic [3:0] AluAdd  = 4'd0;
   localparam logic [3:0] AluSub  = 4'd1;
   localparam logic [3:0] AluAnd  = 4'd2;
   localparam logic [3:0] AluOr   = 4'd3;
   localparam logic [3:0] AluSlt  = 4'd4;
   localparam logic [3:0] AluXor  = 4'd5;
   localparam logic [3:0] AluNor  = 4'd6;
   localparam logic [3:0] AluSll  = 4'd7;
   localparam logic [3:0] AluSrl  = 4'd8;
   localparam logic [3:0] AluSra  = 4'd9;
   localparam logic [3:0] AluSltu = 4'd10;
   localparam logic [3:0] AluLui  = 4'd11;

   // ALUOp values from main control
   localparam logic [3:0] AluOpAdd   = 4'd0;
   localparam logic [3:0] AluOpRType = 4'd1;
   localparam logic [3:0] AluOpSub   = 4'd2;
   localparam logic [3:0] AluOpIType = 4'd3;

   // R-type funct codes
   localparam logic [5:0] FnSll   = 6'h00;
   localparam logic [5:0] FnSrl   = 6'h02;
   localparam logic [5:0] FnSra   = 6'h03;
   localparam logic [5:0] FnJr    = 6'h08;
   localparam logic [5:0] FnMfhi  = 6'h10;
   localparam logic [5:0] FnMflo  = 6'h12;
   localparam logic [5:0] FnMult  = 6'h18;
   localparam logic [5:0] FnMultu = 6'h19;
   localparam logic [5:0] FnDiv   = 6'h1A;
   localparam logic [5:0] FnDivu  = 6'h1B;
   localparam logic [5:0] FnAdd   = 6'h20;
   localparam logic [5:0] FnAddu  = 6'h21;
   localparam logic [5:0] FnSub   = 6'h22;
   localparam logic [5:0] FnSubu  = 6'h23;
   localparam logic [5:0] FnAnd   = 6'h24;
   localparam logic [5:0] FnOr    = 6'h25;
   localparam logic [5:0] FnXor   = 6'h26;
   localparam logic [5:0] FnNor   = 6'h27;
   localparam logic [5:0] FnSlt   = 6'h2A;
   localparam logic [5:0] FnSltu  = 6'h2B;

   // I-type opcodes
   localparam logic [5:0] OpAddi  = 6'h08;
   localparam logic [5:0] OpAddiu = 6'h09;
   localparam logic [5:0] OpSlti  = 6'h0A;
   localparam logic [5:0] OpSltiu = 6'h0B;
   localparam logic [5:0] OpAndi  = 6'h0C;
   localparam logic [5:0] OpOri   = 6'h0D;
   localparam logic [5:0] OpXori  = 6'h0E;
   localparam logic [5:0] OpLui   = 6'h0F;

   typedef enum logic [1:0] {MdMult, MdMultu, MdDiv, MdDivu} mdOp_e;

   typedef enum logic [1:0] {StIdle, StRun, StDone} mdState_e;

   function automatic int unsigned maxLat(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/md_seq_counter.sv
// Loadable down-counter with zero flag; saturates at zero.
module md_seq_counter #(
   parameter int unsigned Width = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             iLoad,
   input  logic [Width-1:0] iLoadVal,
   input  logic             iDec,
   output logic [Width-1:0] oCount,
   output logic             oZero
);

   logic [Width-1:0] cntQ;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cntQ <= '0;
      end else if (iLoad) begin
         cntQ <= iLoadVal;
      end else if (iDec && (cntQ != '0)) begin
         cntQ <= cntQ - 1'b1;
      end
   end

   assign oCount = cntQ;
   assign oZero  = (cntQ == '0);

endmodule

// File: rtl/alu_ctrl_md.sv
// ALU control decoder plus mult/div sequencer with hazard interlock.
// Define ALU_CTRL_DIV_EN to sequence div/divu; otherwise they decode as illegal.
module alu_ctrl_md
   import alu_ctrl_pkg::*;
#(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned MUL_LAT = 4,
   parameter int unsigned DIV_LAT = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       iValid,
   input  logic [3:0] iALUOp,
   input  logic [5:0] iIR_func,
   input  logic       iStall,
   output logic [3:0] oALUctrl,
   output logic       oJR,
   output logic       oIllegal,
   output logic       oMDStart,
   output logic [1:0] oMDOp,
   output logic       oMDBusy,
   output logic       oMDDone,
   output logic       oStall
);

   localparam int unsigned CntW = $clog2(maxLat(MUL_LAT, DIV_LAT));

   if (!(XLEN == 32 || XLEN == 64)) begin : gBadXlen
      $error("alu_ctrl_md: XLEN must be 32 or 64");
   end
   if (MUL_LAT < 2 || MUL_LAT > 64 || DIV_LAT < 2 || DIV_LAT > 64) begin : gBadLat
      $error("alu_ctrl_md: MUL_LAT/DIV_LAT must lie in 2..64");
   end

   logic     [3:0]      aluCtrl;
   logic                jr;
   logic                illegal;
   logic                isMd;
   logic                isHiLo;
   mdOp_e               mdOpSel;
   mdState_e            stateQ;
   mdOp_e               mdOpQ;
   logic                accept;
   logic                lastRun;
   logic     [CntW-1:0] cnt;
   logic     [CntW-1:0] loadVal;
   logic                cntZero;

   always_comb begin
      aluCtrl = AluAdd;
      jr      = 1'b0;
      illegal = 1'b0;
      isMd    = 1'b0;
      isHiLo  = 1'b0;
      mdOpSel = MdMult;
      case (iALUOp)
         AluOpAdd: aluCtrl = AluAdd;
         AluOpSub: aluCtrl = AluSub;
         AluOpRType: begin
            case (iIR_func)
               FnAdd, FnAddu: aluCtrl = AluAdd;
               FnSub, FnSubu: aluCtrl = AluSub;
               FnAnd:         aluCtrl = AluAnd;
               FnOr:          aluCtrl = AluOr;
               FnSlt:         aluCtrl = AluSlt;
               FnXor:         aluCtrl = AluXor;
               FnNor:         aluCtrl = AluNor;
               FnSll:         aluCtrl = AluSll;
               FnSrl:         aluCtrl = AluSrl;
               FnSra:         aluCtrl = AluSra;
               FnSltu:        aluCtrl = AluSltu;
               FnJr:          jr      = 1'b1;
               FnMfhi, FnMflo: isHiLo = 1'b1;
               FnMult: begin
                  isMd    = 1'b1;
                  mdOpSel = MdMult;
               end
               FnMultu: begin
                  isMd    = 1'b1;
                  mdOpSel = MdMultu;
               end
`ifdef ALU_CTRL_DIV_EN
               FnDiv: begin
                  isMd    = 1'b1;
                  mdOpSel = MdDiv;
               end
               FnDivu: begin
                  isMd    = 1'b1;
                  mdOpSel = MdDivu;
               end
`else
               FnDiv, FnDivu: illegal = 1'b1;
`endif
               default: illegal = 1'b1;
            endcase
         end
         AluOpIType: begin
            case (iIR_func)
               OpAddi, OpAddiu: aluCtrl = AluAdd;
               OpAndi:          aluCtrl = AluAnd;
               OpOri:           aluCtrl = AluOr;
               OpXori:          aluCtrl = AluXor;
               OpSlti:          aluCtrl = AluSlt;
               OpSltiu:         aluCtrl = AluSltu;
               OpLui:           aluCtrl = AluLui;
               default:         illegal = 1'b1;
            endcase
         end
         default: illegal = 1'b1;
      endcase
   end

   assign oALUctrl = aluCtrl;
   assign oJR      = jr;
   assign oIllegal = illegal & iValid;

   // Interlock only while the unit is running; DONE already has HI/LO valid.
   assign oStall = ~rst & iValid & (isMd | isHiLo) & (stateQ == StRun);
   assign accept = ~rst & iValid & isMd & ~iStall & ~oStall &
                   ((stateQ == StIdle) || (stateQ == StDone));

   // Counter holds LAT-1 on entering RUN; leaving RUN as it reaches zero gives LAT total.
   assign loadVal = mdOpSel[1] ? CntW'(DIV_LAT - 1) : CntW'(MUL_LAT - 1);
   assign lastRun = (cnt == CntW'(1)) || cntZero;

   md_seq_counter #(
      .Width (CntW)
   ) uCounter (
      .clk      (clk),
      .rst      (rst),
      .iLoad    (accept),
      .iLoadVal (loadVal),
      .iDec     (stateQ == StRun),
      .oCount   (cnt),
      .oZero    (cntZero)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stateQ <= StIdle;
         mdOpQ  <= MdMult;
      end else begin
         unique case (stateQ)
            StIdle, StDone: begin
               if (accept) begin
                  stateQ <= StRun;
                  mdOpQ  <= mdOpSel;
               end else begin
                  stateQ <= StIdle;
               end
            end
            StRun: begin
               if (lastRun) stateQ <= StDone;
            end
            default: stateQ <= StIdle;
         endcase
      end
   end

   assign oMDStart = accept;
   assign oMDOp    = mdOpQ;
   assign oMDBusy  = (stateQ == StRun);
   assign oMDDone  = (stateQ == StDone);

endmodule

// File: tb/tb_alu_ctrl_md.sv
// Directed bench for alu_ctrl_md: decode table, mult/div sequencing, interlock, async reset.
module tb_alu_ctrl_md;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       iValid = 1'b0;
   logic [3:0] iALUOp = 4'd0;
   logic [5:0] iIR_func = 6'd0;
   logic       iStall = 1'b0;
   logic [3:0] oALUctrl;
   logic       oJR;
   logic       oIllegal;
   logic       oMDStart;
   logic [1:0] oMDOp;
   logic       oMDBusy;
   logic       oMDDone;
   logic       oStall;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   alu_ctrl_md #(
      .XLEN    (32),
      .MUL_LAT (4),
      .DIV_LAT (32)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .iValid   (iValid),
      .iALUOp   (iALUOp),
      .iIR_func (iIR_func),
      .iStall   (iStall),
      .oALUctrl (oALUctrl),
      .oJR      (oJR),
      .oIllegal (oIllegal),
      .oMDStart (oMDStart),
      .oMDOp    (oMDOp),
      .oMDBusy  (oMDBusy),
      .oMDDone  (oMDDone),
      .oStall   (oStall)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic nx();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input logic v, input logic [3:0] op, input logic [5:0] f, input logic st);
      iValid   = v;
      iALUOp   = op;
      iIR_func = f;
      iStall   = st;
   endtask

   task automatic md(input string t, input logic s, input logic b, input logic d,
                     input logic [1:0] opv);
      chk({t, "_start"}, oMDStart, s);
      chk({t, "_busy"}, oMDBusy, b);
      chk({t, "_done"}, oMDDone, d);
      chk({t, "_op"}, oMDOp, opv);
   endtask

   task automatic dec(input string t, input logic v, input logic [3:0] op, input logic [5:0] f,
                      input logic [3:0] eCtrl, input logic eJr, input logic eIll);
      drv(v, op, f, 1'b0);
      #1;
      chk({t, "_ctrl"}, oALUctrl, eCtrl);
      chk({t, "_jr"}, oJR, eJr);
      chk({t, "_ill"}, oIllegal, eIll);
   endtask

   initial begin
      #2;
      md("rst", 1'b0, 1'b0, 1'b0, 2'd0);
      chk("rst_stall", oStall, 1'b0);
      drv(1'b1, 4'd1, 6'h18, 1'b0);
      #1;
      chk("rst_mult_start", oMDStart, 1'b0);
      chk("rst_mult_stall", oStall, 1'b0);
      drv(1'b1, 4'd1, 6'h2A, 1'b0);
      #1;
      chk("rst_dec_follow", oALUctrl, 4'd4);
      nx();
      nx();
      rst = 1'b0;
      drv(1'b0, 4'd0, 6'd0, 1'b0);
      #4;
      md("idle", 1'b0, 1'b0, 1'b0, 2'd0);

      // Combinational decode
      dec("aluop0", 1'b1, 4'd0, 6'h3F, 4'd0, 1'b0, 1'b0);
      dec("aluop2", 1'b1, 4'd2, 6'h00, 4'd1, 1'b0, 1'b0);
      dec("slt", 1'b1, 4'd1, 6'h2A, 4'd4, 1'b0, 1'b0);
      dec("sltu", 1'b1, 4'd1, 6'h2B, 4'd10, 1'b0, 1'b0);
      dec("jr", 1'b1, 4'd1, 6'h08, 4'd0, 1'b1, 1'b0);
      dec("bad_r", 1'b1, 4'd1, 6'h3F, 4'd0, 1'b0, 1'b1);
      dec("bad_r_nv", 1'b0, 4'd1, 6'h3F, 4'd0, 1'b0, 1'b0);
      dec("nor", 1'b1, 4'd1, 6'h27, 4'd6, 1'b0, 1'b0);
      dec("sra", 1'b1, 4'd1, 6'h03, 4'd9, 1'b0, 1'b0);
      dec("subu", 1'b1, 4'd1, 6'h23, 4'd1, 1'b0, 1'b0);
      dec("lui", 1'b1, 4'd3, 6'h0F, 4'd11, 1'b0, 1'b0);
      dec("sltiu", 1'b1, 4'd3, 6'h0B, 4'd10, 1'b0, 1'b0);
      dec("ori", 1'b1, 4'd3, 6'h0D, 4'd3, 1'b0, 1'b0);
      dec("bad_i", 1'b1, 4'd3, 6'h04, 4'd0, 1'b0, 1'b1);
      dec("mflo", 1'b1, 4'd1, 6'h12, 4'd0, 1'b0, 1'b0);
`ifndef ALU_CTRL_DIV_EN
      dec("div_off", 1'b1, 4'd1, 6'h1A, 4'd0, 1'b0, 1'b1);
      chk("div_off_start", oMDStart, 1'b0);
      nx();
      drv(1'b0, 4'd0, 6'd0, 1'b0);
      #4;
      md("div_off_idle", 1'b0, 1'b0, 1'b0, 2'd0);
`endif

      // iStall blocks acceptance
      nx();
      drv(1'b1, 4'd1, 6'h18, 1'b1);
      #4;
      chk("stall_block_start", oMDStart, 1'b0);
      nx();
      drv(1'b0, 4'd0, 6'd0, 1'b0);
      #4;
      chk("stall_block_busy", oMDBusy, 1'b0);

      // mult, MUL_LAT=4, with mflo interlocked during RUN
      nx();
      drv(1'b1, 4'd1, 6'h18, 1'b0);
      #4;
      md("m0", 1'b1, 1'b0, 1'b0, 2'd0);
      nx();
      drv(1'b0, 4'd0, 6'd0, 1'b0);
      #4;
      md("m1", 1'b0, 1'b1, 1'b0, 2'd0);
      chk("m1_stall", oStall, 1'b0);
      nx();
      drv(1'b1, 4'd1, 6'h12, 1'b0);
      #4;
      md("m2", 1'b0, 1'b1, 1'b0, 2'd0);
      chk("m2_stall", oStall, 1'b1);
      nx();
      drv(1'b1, 4'd1, 6'h12, 1'b1);
      #4;
      md("m3", 1'b0, 1'b1, 1'b0, 2'd0);
      chk("m3_stall", oStall, 1'b1);
      nx();
      drv(1'b1, 4'd1, 6'h12, 1'b0);
      #4;
      md("m4", 1'b0, 1'b0, 1'b1, 2'd0);
      chk("m4_stall", oStall, 1'b0);

      // mult then multu chained in the DONE cycle
      nx();
      drv(1'b1, 4'd1, 6'h18, 1'b0);
      #4;
      md("c0", 1'b1, 1'b0, 1'b0, 2'd0);
      for (int i = 1; i < 4; i++) begin
         nx();
         drv(1'b0, 4'd0, 6'd0, 1'b0);
         #4;
         chk("c_busy", oMDBusy, 1'b1);
      end
      nx();
      drv(1'b1, 4'd1, 6'h19, 1'b0);
      #4;
      md("c4", 1'b1, 1'b0, 1'b1, 2'd0);
      for (int i = 5; i < 8; i++) begin
         nx();
         drv(1'b0, 4'd0, 6'd0, 1'b1);
         #4;
         md("c_run2", 1'b0, 1'b1, 1'b0, 2'd1);
      end
      nx();
`ifdef ALU_CTRL_DIV_EN
      drv(1'b1, 4'd1, 6'h1B, 1'b0);
      #4;
      md("c8", 1'b1, 1'b0, 1'b1, 2'd1);
      for (int i = 1; i < 32; i++) begin
         nx();
         drv(1'b0, 4'd0, 6'd0, 1'b0);
         #4;
         md("divu_run", 1'b0, 1'b1, 1'b0, 2'd3);
      end
      nx();
      #4;
      md("divu_done", 1'b0, 1'b0, 1'b1, 2'd3);
`else
      drv(1'b1, 4'd1, 6'h1A, 1'b0);
      #4;
      md("c8", 1'b0, 1'b0, 1'b1, 2'd1);
      chk("c8_ill", oIllegal, 1'b1);
`endif
      nx();
      drv(1'b0, 4'd0, 6'd0, 1'b0);
      #4;
      chk("after_busy", oMDBusy, 1'b0);
      chk("after_done", oMDDone, 1'b0);

      // Asynchronous reset in the middle of RUN
      nx();
`ifdef ALU_CTRL_DIV_EN
      drv(1'b1, 4'd1, 6'h1B, 1'b0);
      #4;
      chk("r_start", oMDStart, 1'b1);
      for (int i = 1; i <= 15; i++) begin
         nx();
         drv(1'b0, 4'd0, 6'd0, 1'b0);
      end
`else
      drv(1'b1, 4'd1, 6'h18, 1'b0);
      #4;
      chk("r_start", oMDStart, 1'b1);
      for (int i = 1; i <= 2; i++) begin
         nx();
         drv(1'b0, 4'd0, 6'd0, 1'b0);
      end
`endif
      #1;
      chk("r_pre_busy", oMDBusy, 1'b1);
      rst = 1'b1;
      #1;
      md("r_async", 1'b0, 1'b0, 1'b0, 2'd0);
      nx();
      #4;
      md("r_held", 1'b0, 1'b0, 1'b0, 2'd0);
      nx();
      rst = 1'b0;
      drv(1'b1, 4'd1, 6'h18, 1'b0);
      #4;
      md("r_new0", 1'b1, 1'b0, 1'b0, 2'd0);
      nx();
      drv(1'b0, 4'd0, 6'd0, 1'b0);
      #4;
      md("r_new1", 1'b0, 1'b1, 1'b0, 2'd0);
      nx();
      nx();
      nx();
      #4;
      md("r_new4", 1'b0, 1'b0, 1'b1, 2'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
